// File: rtl/bpu_btb_bht.sv
// bpu_btb_bht: direct-mapped BTB with 2-bit direction counters, IF lookup and EX training.
// Optional BPU_STATS_EN adds saturating lookup/hit/mispredict counters.
module bpu_btb_bht #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_req_valid,
    input  logic            fetch_req_ready,
    input  logic [XLEN-1:0] fetch_addr,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_cond,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            mispredict,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            btb_flush,
    output logic [XLEN-1:0] next_pc,
    output logic            pred_taken,
    output logic            pred_hit
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_hits,
    output logic [31:0]     stat_mispredicts
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [XLEN-1:0]  tgt_q   [ENTRIES];
    logic             unc_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic [XLEN-1:0]  seq_pc;
    logic             f_hit, f_take, u_hit, u_taken;

    assign f_idx   = fetch_addr[IDX_W+1:2];
    assign f_tag   = fetch_addr[XLEN-1:IDX_W+2];
    assign u_idx   = upd_pc[IDX_W+1:2];
    assign u_tag   = upd_pc[XLEN-1:IDX_W+2];
    assign seq_pc  = fetch_addr + XLEN'(4);
    // rst forces a miss so lookups during reset never see stale entries
    assign f_hit   = !rst && valid_q[f_idx] && tag_q[f_idx] == f_tag;
    assign f_take  = f_hit && (unc_q[f_idx] || ctr_q[f_idx][1]);
    assign u_hit   = valid_q[u_idx] && tag_q[u_idx] == u_tag;
    assign u_taken = upd_taken || !upd_is_cond;

    assign next_pc    = mispredict ? redirect_pc : f_take ? tgt_q[f_idx] : seq_pc;
    assign pred_taken = !mispredict && f_take && tgt_q[f_idx] != seq_pc;
    assign pred_hit   = !mispredict && f_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                unc_q[i]   <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (btb_flush) begin
            for (int i = 0; i < ENTRIES; i++)
                valid_q[i] <= 1'b0;
        end else if (upd_valid && u_hit) begin
            ctr_q[u_idx] <= !upd_is_cond ? 2'b11 :
                            upd_taken ? (ctr_q[u_idx] == 2'b11 ? 2'b11 : ctr_q[u_idx] + 2'b01) :
                                        (ctr_q[u_idx] == 2'b00 ? 2'b00 : ctr_q[u_idx] - 2'b01);
            unc_q[u_idx] <= !upd_is_cond;
            if (u_taken)
                tgt_q[u_idx] <= upd_target;
        end else if (upd_valid && u_taken) begin
            valid_q[u_idx] <= 1'b1;
            tag_q[u_idx]   <= u_tag;
            tgt_q[u_idx]   <= upd_target;
            unc_q[u_idx]   <= !upd_is_cond;
            ctr_q[u_idx]   <= upd_is_cond ? 2'b10 : 2'b11;
        end
    end

`ifdef BPU_STATS_EN
    logic acc;
    assign acc = fetch_req_valid && fetch_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups     <= '0;
            stat_hits        <= '0;
            stat_mispredicts <= '0;
        end else begin
            stat_lookups     <= stat_lookups + 32'(acc && stat_lookups != '1);
            stat_hits        <= stat_hits + 32'(acc && pred_hit && stat_hits != '1);
            stat_mispredicts <= stat_mispredicts + 32'(mispredict && stat_mispredicts != '1);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{fetch_addr[1:0], upd_pc[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{fetch_addr[1:0], upd_pc[1:0], fetch_req_valid, fetch_req_ready};
`endif
endmodule

// File: tb/tb_bpu_btb_bht.sv
// tb_bpu_btb_bht: directed plus random stimulus against an entry-level behavioural model.
module tb_bpu_btb_bht;
    localparam int N  = 16;
    localparam int IW = 4;

    logic        clk = 1'b0;
    logic        rst, fetch_req_valid, fetch_req_ready, upd_valid, upd_is_cond, upd_taken;
    logic        mispredict, btb_flush, pred_taken, pred_hit;
    logic [31:0] fetch_addr, upd_pc, upd_target, redirect_pc, next_pc;

    int checks = 0;
    int errors = 0;

    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    bit          m_unc   [N];
    int          m_ctr   [N];

    always #5 clk = ~clk;

    bpu_btb_bht #(.ENTRIES(N), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
        .fetch_addr(fetch_addr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .btb_flush(btb_flush),
        .next_pc(next_pc), .pred_taken(pred_taken), .pred_hit(pred_hit)
    );

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic model_check();
        int i;
        bit h, t;
        logic [31:0] seq, e_next;
        i = int'((fetch_addr / 4) % N);
        h = !rst && m_valid[i] && m_tag[i] == fetch_addr / (4 * N);
        t = h && (m_unc[i] || m_ctr[i] >= 2);
        seq = fetch_addr + 4;
        e_next = mispredict ? redirect_pc : t ? m_tgt[i] : seq;
        chk("model_next_pc", next_pc, e_next);
        chk("model_pred_taken", 32'(pred_taken), 32'(!mispredict && t && m_tgt[i] != seq));
        chk("model_pred_hit", 32'(pred_hit), 32'(!mispredict && h));
    endtask

    task automatic model_update();
        int i;
        bit h, tk;
        i = int'((upd_pc / 4) % N);
        h = m_valid[i] && m_tag[i] == upd_pc / (4 * N);
        tk = upd_taken || !upd_is_cond;
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_unc[k] = 0; m_ctr[k] = 1;
            end
        end else if (btb_flush) begin
            for (int k = 0; k < N; k++) m_valid[k] = 0;
        end else if (upd_valid && h) begin
            if (!upd_is_cond) m_ctr[i] = 3;
            else if (upd_taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            else m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            m_unc[i] = !upd_is_cond;
            if (tk) m_tgt[i] = upd_target;
        end else if (upd_valid && tk) begin
            m_valid[i] = 1; m_tag[i] = upd_pc / (4 * N); m_tgt[i] = upd_target;
            m_unc[i] = !upd_is_cond; m_ctr[i] = upd_is_cond ? 2 : 3;
        end
    endtask

    task automatic clear_in();
        rst = 0; fetch_req_valid = 0; fetch_req_ready = 0; upd_valid = 0; upd_pc = 0;
        upd_is_cond = 0; upd_taken = 0; upd_target = 0; mispredict = 0; redirect_pc = 0;
        btb_flush = 0;
    endtask

    task automatic upd(input logic [31:0] pc, input bit cond, input bit tk, input logic [31:0] tgt);
        upd_valid = 1; upd_pc = pc; upd_is_cond = cond; upd_taken = tk; upd_target = tgt;
    endtask

    task automatic settle();
        #1 model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_unc[k] = 0; m_ctr[k] = 1;
        end
        clear_in();
        rst = 1;
        fetch_addr = 32'h100;
        @(negedge clk);
        settle();
        chk("rst_hit", 32'(pred_hit), 0);
        chk("rst_next", next_pc, 32'h104);
        adv();
        rst = 0;
        settle();
        chk("post_rst_next", next_pc, 32'h104);
        chk("post_rst_hit", 32'(pred_hit), 0);
        chk("post_rst_taken", 32'(pred_taken), 0);
        fetch_addr = 32'hFFFF_FFFC;
        settle();
        chk("wrap_next", next_pc, 32'h0);
        adv();

        fetch_addr = 32'h100;
        upd(32'h100, 1, 1, 32'h200);
        settle();
        chk("same_cycle_old", next_pc, 32'h104);
        adv();
        clear_in();
        settle();
        chk("alloc_hit", 32'(pred_hit), 1);
        chk("alloc_next", next_pc, 32'h200);
        chk("alloc_taken", 32'(pred_taken), 1);

        repeat (2) begin
            upd(32'h100, 1, 0, 32'h0);
            settle();
            adv();
        end
        clear_in();
        settle();
        chk("ctr00_next", next_pc, 32'h104);
        chk("ctr00_hit", 32'(pred_hit), 1);

        repeat (4) begin
            upd(32'h100, 1, 1, 32'h200);
            settle();
            adv();
        end
        upd(32'h100, 1, 0, 32'h0);
        settle();
        adv();
        clear_in();
        settle();
        chk("sat_hold_next", next_pc, 32'h200);

        upd(32'h140, 0, 0, 32'h300);
        settle();
        adv();
        clear_in();
        settle();
        chk("evict_next", next_pc, 32'h104);
        chk("evict_hit", 32'(pred_hit), 0);
        fetch_addr = 32'h140;
        settle();
        chk("jal_next", next_pc, 32'h300);
        chk("jal_hit", 32'(pred_hit), 1);
        chk("jal_taken", 32'(pred_taken), 1);

        mispredict = 1;
        redirect_pc = 32'h800;
        settle();
        chk("misp_next", next_pc, 32'h800);
        chk("misp_taken", 32'(pred_taken), 0);
        chk("misp_hit", 32'(pred_hit), 0);
        mispredict = 0;

        upd(32'h10, 1, 1, 32'h14);
        settle();
        adv();
        clear_in();
        fetch_addr = 32'h10;
        settle();
        chk("seq_tgt_hit", 32'(pred_hit), 1);
        chk("seq_tgt_next", next_pc, 32'h14);
        chk("seq_tgt_taken", 32'(pred_taken), 0);

        btb_flush = 1;
        upd(32'h180, 1, 1, 32'h400);
        settle();
        adv();
        clear_in();
        fetch_addr = 32'h140;
        settle();
        chk("flush_hit", 32'(pred_hit), 0);
        chk("flush_next", next_pc, 32'h144);
        fetch_addr = 32'h180;
        settle();
        chk("flush_drop_hit", 32'(pred_hit), 0);
        chk("flush_drop_next", next_pc, 32'h184);
        adv();

        repeat (3000) begin
            rst = ($urandom_range(0, 199) == 0);
            btb_flush = ($urandom_range(0, 49) == 0);
            mispredict = ($urandom_range(0, 7) == 0);
            redirect_pc = $urandom;
            fetch_req_valid = 1'($urandom);
            fetch_req_ready = 1'($urandom);
            fetch_addr = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) fetch_addr = fetch_addr | 32'hFFFF_FF00;
            upd_valid = 1'($urandom);
            upd_pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            upd_is_cond = ($urandom_range(0, 3) != 0);
            upd_taken = 1'($urandom);
            upd_target = ($urandom_range(0, 3) == 0) ? fetch_addr + 4 : $urandom;
            settle();
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
